// File: rtl/run_detect_arbiter.sv
// run_detect_arbiter
// Round-robin scheduler sharing one run-length pattern engine among N_REQ
// serial-bit requesters. The granted requester streams one frame of FRAME_LEN
// accepted bits. Every accepted bit that completes or extends a run of at
// least RUN_LEN equal bits is flagged on match and counted. At frame end the
// per-frame hit count is reported with done, then the grant rotates.

module run_detect_arbiter #(
   parameter int N_REQ     = 4,
   parameter int FRAME_LEN = 16,
   parameter int RUN_LEN   = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N_REQ-1:0]               req,
   input  logic [N_REQ-1:0]               bit_in,
   input  logic [N_REQ-1:0]               bit_valid,
   output logic [N_REQ-1:0]               grant,
   output logic                           match,
   output logic                           done,
   output logic [$clog2(N_REQ)-1:0]       done_id,
   output logic [$clog2(FRAME_LEN+1)-1:0] hit_count,
   output logic                           aborted
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam int RUN_W = $clog2(RUN_LEN + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Architectural state
   state_t            state_q;
   logic [ID_W-1:0]   rr_ptr_q;
   logic [ID_W-1:0]   gidx_q;
   logic [N_REQ-1:0]  grant_q;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [RUN_W-1:0]  run_q;
   logic              last_bit_q;
   logic [CNT_W-1:0]  hit_cnt_q;

   // Registered outputs
   logic              match_q;
   logic              done_q;
   logic [ID_W-1:0]   done_id_q;
   logic [CNT_W-1:0]  hit_count_q;
   logic              aborted_q;

   // Arbitration results
   logic              pick_found_d;
   logic [ID_W-1:0]   pick_idx_d;
   logic [N_REQ-1:0]  pick_onehot_d;

   // Granted-lane view and run engine next values
   logic              lane_bit_d;
   logic              lane_valid_d;
   logic              lane_req_d;
   logic              first_bit_d;
   logic              same_bit_d;
   logic [RUN_W-1:0]  run_d;
   logic              hit_d;
   logic [CNT_W-1:0]  hit_cnt_d;
   logic [CNT_W-1:0]  bit_cnt_d;
   logic              last_acc_d;
   logic [ID_W-1:0]   rr_next_d;

   // Round-robin pick: first requester at or after rr_ptr, wrapping upward.
   // Scanning from the farthest offset down lets the nearest one win.
   always_comb begin
      logic [ID_W-1:0] idx_v;
      idx_v         = '0;
      pick_found_d  = 1'b0;
      pick_idx_d    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx_v        = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
         pick_found_d = pick_found_d | req[idx_v];
         pick_idx_d   = req[idx_v] ? idx_v : pick_idx_d;
      end
      pick_onehot_d = N_REQ'(1) << pick_idx_d;
   end

   // Select the granted lane and compute the saturating run update.
   always_comb begin
      lane_bit_d   = bit_in[gidx_q];
      lane_valid_d = bit_valid[gidx_q];
      lane_req_d   = req[gidx_q];
      first_bit_d  = (bit_cnt_q == CNT_W'(0));
      same_bit_d   = (lane_bit_d == last_bit_q);
      if (first_bit_d) begin
         run_d = RUN_W'(1);
      end else if (same_bit_d) begin
         run_d = (run_q == RUN_W'(RUN_LEN)) ? run_q : (run_q + RUN_W'(1));
      end else begin
         run_d = RUN_W'(1);
      end
      hit_d      = (run_d == RUN_W'(RUN_LEN));
      hit_cnt_d  = hit_d ? (hit_cnt_q + CNT_W'(1)) : hit_cnt_q;
      bit_cnt_d  = bit_cnt_q + CNT_W'(1);
      last_acc_d = lane_valid_d && (bit_cnt_q == CNT_W'(FRAME_LEN - 1));
      rr_next_d  = (gidx_q == ID_W'(N_REQ - 1)) ? ID_W'(0) : (gidx_q + ID_W'(1));
   end

   // Scheduler FSM with run engine, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         gidx_q      <= '0;
         grant_q     <= '0;
         bit_cnt_q   <= '0;
         run_q       <= '0;
         last_bit_q  <= 1'b0;
         hit_cnt_q   <= '0;
         match_q     <= 1'b0;
         done_q      <= 1'b0;
         done_id_q   <= '0;
         hit_count_q <= '0;
         aborted_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               match_q     <= 1'b0;
               done_q      <= 1'b0;
               done_id_q   <= '0;
               hit_count_q <= '0;
               aborted_q   <= 1'b0;
               if (pick_found_d) begin
                  grant_q    <= pick_onehot_d;
                  gidx_q     <= pick_idx_d;
                  bit_cnt_q  <= '0;
                  run_q      <= '0;
                  last_bit_q <= 1'b0;
                  hit_cnt_q  <= '0;
                  state_q    <= ST_SCAN;
               end else begin
                  grant_q <= '0;
                  state_q <= ST_IDLE;
               end
            end

            ST_SCAN: begin
               if (!lane_req_d && !last_acc_d) begin
                  // Requester gave up: any bit offered this cycle is dropped.
                  grant_q     <= '0;
                  match_q     <= 1'b0;
                  done_q      <= 1'b1;
                  done_id_q   <= gidx_q;
                  hit_count_q <= hit_cnt_q;
                  aborted_q   <= 1'b1;
                  state_q     <= ST_DONE;
               end else if (lane_valid_d) begin
                  run_q      <= run_d;
                  last_bit_q <= lane_bit_d;
                  hit_cnt_q  <= hit_cnt_d;
                  bit_cnt_q  <= bit_cnt_d;
                  match_q    <= hit_d;
                  if (last_acc_d) begin
                     grant_q     <= '0;
                     done_q      <= 1'b1;
                     done_id_q   <= gidx_q;
                     hit_count_q <= hit_cnt_d;
                     aborted_q   <= 1'b0;
                     state_q     <= ST_DONE;
                  end else begin
                     state_q <= ST_SCAN;
                  end
               end else begin
                  // Gap cycle: engine state holds, no flag.
                  match_q <= 1'b0;
                  state_q <= ST_SCAN;
               end
            end

            ST_DONE: begin
               grant_q     <= '0;
               match_q     <= 1'b0;
               done_q      <= 1'b0;
               done_id_q   <= '0;
               hit_count_q <= '0;
               aborted_q   <= 1'b0;
               rr_ptr_q    <= rr_next_d;
               state_q     <= ST_IDLE;
            end

            default: begin
               grant_q     <= '0;
               match_q     <= 1'b0;
               done_q      <= 1'b0;
               done_id_q   <= '0;
               hit_count_q <= '0;
               aborted_q   <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant     = grant_q;
   assign match     = match_q;
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign hit_count = hit_count_q;
   assign aborted   = aborted_q;

endmodule

// File: tb/tb_run_detect_arbiter.sv
// Scoreboard bench for run_detect_arbiter: the driver models each frame from
// the rules (last RUN_LEN accepted bits equal => hit) and queues the expected
// report; an independent monitor collects grant/match per frame and checks
// it against the queue whenever done is presented.

module tb_run_detect_arbiter;

   localparam int N  = 4;
   localparam int FL = 8;
   localparam int RL = 3;
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(FL + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req, bit_in, bit_valid, grant;
   logic          match, done, aborted;
   logic [IW-1:0] done_id;
   logic [CW-1:0] hit_count;

   int vectors = 0;
   int miscompares = 0;
   int rr_model = 0;

   typedef struct {
      int           id;
      int           hits;
      int           ab;
      int           tlen;
      logic [255:0] tr;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   run_detect_arbiter #(.N_REQ(N), .FRAME_LEN(FL), .RUN_LEN(RL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .grant     (grant),
      .match     (match),
      .done      (done),
      .done_id   (done_id),
      .hit_count (hit_count),
      .aborted   (aborted)
   );

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r);
      for (int i = 0; i < N; i++) begin
         if (r[(rr_model + i) % N]) return (rr_model + i) % N;
      end
      return -1;
   endfunction

   // Monitor: accumulate the match trace of the current frame, check on done
   int           m_tlen = 0;
   logic [255:0] m_tr = '0;
   logic [N-1:0] m_grant = '0;
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
         m_tlen  = 0;
         m_tr    = '0;
         m_grant = '0;
      end else begin
         if ((grant != '0 || done) && m_tlen < 256) begin
            m_tr[m_tlen] = match;
            m_tlen++;
         end
         if (grant != '0 && m_grant == '0) m_grant = grant;
         if (done) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_done: got done with done_id=%0d, required no done", done_id);
            end else begin
               e = sb.pop_front();
               chk("done_id", int'(done_id), e.id);
               chk("hit_count", int'(hit_count), e.hits);
               chk("aborted", int'(aborted), e.ab);
               chk("grant_onehot", int'(m_grant), 1 << e.id);
               chk("trace_len", m_tlen, e.tlen);
               vectors++;
               if (m_tr !== e.tr) begin
                  miscompares++;
                  $display("FAIL match_trace: got %h, required %h", m_tr[63:0], e.tr[63:0]);
               end
            end
            m_tlen  = 0;
            m_tr    = '0;
            m_grant = '0;
         end
      end
   end

   // Drive one frame on the model-chosen lane and queue the expected report.
   // gap_mode: 0 always valid, 1 random gaps, 2 gap only at scan cycle 2.
   task automatic run_frame(input logic [N-1:0] reqv, input logic [FL-1:0] pat,
                            input int rnd_bits, input int gap_mode,
                            input int abort_after, output int wait_cycles);
      int   id, acc, cyc, hits, ab;
      bit   v, b, drop, comp, hit;
      exp_t e;
      int   hist[$];
      req = reqv;
      id  = pick(reqv);
      wait_cycles = 0;
      while (grant == '0 && wait_cycles < 20) begin
         bit_in    = N'($urandom);
         bit_valid = N'($urandom);
         @(posedge clk); #1;
         wait_cycles++;
      end
      if (grant == '0) begin
         vectors++;
         miscompares++;
         $display("FAIL grant_timeout: got grant=0 after %0d cycles, required lane %0d", wait_cycles, id);
         return;
      end
      rr_model = (id + 1) % N;
      e.tr = '0;
      e.tlen = 1;
      acc = 0; cyc = 0; hits = 0; ab = 0;
      forever begin
         drop = (abort_after >= 0 && acc == abort_after);
         case (gap_mode)
            0:       v = 1'b1;
            1:       v = (cyc >= 40) || ($urandom_range(0, 99) >= 30);
            default: v = (cyc != 2);
         endcase
         b = (rnd_bits != 0) ? 1'($urandom_range(0, 1)) : pat[acc];
         bit_in        = N'($urandom);
         bit_valid     = N'($urandom);
         bit_in[id]    = b;
         bit_valid[id] = v;
         if (drop) req[id] = 1'b0;
         comp = v && (acc == FL - 1);
         hit  = 1'b0;
         if (drop && !comp) begin
            ab = 1;
         end else if (v) begin
            hist.push_back(int'(b));
            acc++;
            if (hist.size() >= RL) begin
               hit = 1'b1;
               for (int k = 1; k < RL; k++) begin
                  if (hist[hist.size() - 1 - k] != int'(b)) hit = 1'b0;
               end
            end
            hits += int'(hit);
         end
         e.tr[e.tlen] = hit;
         e.tlen++;
         @(posedge clk); #1;
         cyc++;
         if (ab != 0 || comp) break;
      end
      e.id = id;
      e.hits = hits;
      e.ab = ab;
      sb.push_back(e);
      bit_valid = '0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin : stim
      int w;
      rst_n = 1'b0; req = '0; bit_in = '0; bit_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", int'(grant), 0);
      chk("rst_match", int'(match), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_done_id", int'(done_id), 0);
      chk("rst_hit_count", int'(hit_count), 0);
      chk("rst_aborted", int'(aborted), 0);
      rst_n = 1'b1;

      // Directed frames on requester 1
      run_frame(4'b0010, 8'b11000111, 0, 0, -1, w);
      run_frame(4'b0010, 8'b11111111, 0, 0, -1, w);
      run_frame(4'b0010, 8'b01010101, 0, 0, -1, w);
      // Gap inside a run of zeros: 0,0,_,0,1,1,0,1,0
      run_frame(4'b0001, 8'b01011000, 0, 2, -1, w);
      // Requester 2 drops after 5 accepted bits, then next requester served
      run_frame(4'b0100, 8'b00011111, 0, 0, 5, w);
      run_frame(4'b1100, 8'b00000000, 1, 0, -1, w);
      // All requesting: rotation 0,1,2,3,0 with a two-cycle grant gap
      for (int f = 0; f < 5; f++) begin
         run_frame(4'b1111, 8'b00000000, 1, 0, -1, w);
         chk("grant_gap", w, 2);
      end

      // Mid-frame asynchronous reset
      req = 4'b1111;
      w = 0;
      while (grant == '0 && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      bit_valid = 4'b1111;
      bit_in    = 4'b1111;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_grant", int'(grant), 0);
      chk("arst_match", int'(match), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_hit_count", int'(hit_count), 0);
      chk("arst_aborted", int'(aborted), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bit_valid = '0;
      rr_model = 0;
      run_frame(4'b1111, 8'b00000000, 1, 0, -1, w);

      // Randomized frames
      for (int f = 0; f < 40; f++) begin
         run_frame(N'($urandom_range(1, 15)), 8'b00000000, 1,
                   ($urandom_range(0, 1) != 0) ? 1 : 0,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, FL - 1) : -1, w);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/run_detect_arbiter.md
# run_detect_arbiter

Round-robin scheduler that shares one run-length pattern engine among `N_REQ` serial-bit requesters. Each granted requester streams one frame of `FRAME_LEN` bits. The engine flags every bit at which `RUN_LEN` or more consecutive equal bits (all ones or all zeros) have been seen. At frame end the block reports a per-frame hit count to the requester, then rotates the grant.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `FRAME_LEN`, 16, accepted bits per frame (2..255)
- `RUN_LEN`, 3, equal-bit run length that constitutes a hit (2..FRAME_LEN)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `req`  in  N_REQ  per-requester frame request, level; held high for the whole frame
- `bit_in`  in  N_REQ  per-requester serial data bit
- `bit_valid`  in  N_REQ  per-requester data qualifier; only the granted lane is sampled
- `grant`  out  N_REQ  one-hot grant, registered; all-zero when no frame is active
- `match`  out  1  registered; high the cycle after an accepted bit completes or extends a run ≥ `RUN_LEN`
- `done`  out  1  one-cycle pulse at frame end (normal or aborted)
- `done_id`  out  clog2(N_REQ)  index of the finished requester; valid with `done`
- `hit_count`  out  clog2(FRAME_LEN+1)  number of accepted bits flagged as hits; valid with `done`
- `aborted`  out  1  with `done`: frame ended early because `req` dropped

## Operation
- FSM states: IDLE, SCAN, DONE.
- **IDLE**
  - If any `req` is high, choose the first requester at or after `rr_ptr`, scanning upward with wrap at N_REQ-1→0.
  - Register `grant`, clear the bit counter, run counter, `last_bit` and hit counter, then go to SCAN.
  - With no `req`, remain in IDLE.
- **SCAN** (granted index g)
  - A bit is accepted when `bit_valid[g]` is high. Other lanes are ignored.
  - First accepted bit of a frame: run = 1.
  - Later accepted bits: run = (`bit_in[g]` == `last_bit`) ? min(run+1, RUN_LEN) : 1. Then `last_bit` ← `bit_in[g]`.
  - Hit: the updated run equals `RUN_LEN`. On a hit, `match` ← 1 next cycle and the hit counter increments. Otherwise `match` ← 0.
  - On the `FRAME_LEN`-th accepted bit, go to DONE with `aborted` = 0.
  - If `req[g]` is low in SCAN and the cycle does not complete the frame, go to DONE with `aborted` = 1. A bit accepted in that same cycle is discarded.
- **DONE**
  - Outputs for one cycle: `done` = 1, `done_id` = g, `hit_count`, `aborted`.
  - `grant` = 0. `rr_ptr` ← (g+1) mod N_REQ. Return to IDLE.
- Arithmetic rules:
  - Run counter saturates at `RUN_LEN` and never wraps.
  - Hit counter is bounded by `FRAME_LEN`; `hit_count` width always holds the value.
- Requests arriving in SCAN or DONE wait and are arbitrated in the next IDLE.
- `bit_in`/`bit_valid` outside SCAN are ignored.

## Timing
- Reset (`rst_n` low, asynchronous, at any time including mid-frame):
  - state = IDLE, `rr_ptr` = 0.
  - `grant`, `match`, `done`, `done_id`, `hit_count`, `aborted` = 0.
  - All counters and `last_bit` = 0.
  - The frame in progress is lost and no `done` is issued.
- Request to grant: `req` high in IDLE at edge k → `grant` high after edge k; the first bit can be accepted at edge k+1.
- With continuous `bit_valid`, a frame occupies `FRAME_LEN` SCAN cycles plus 1 DONE cycle plus 1 IDLE cycle.
  - Back-to-back grant gap: `grant` is low for 2 cycles (DONE, IDLE).
- `match` lags its accepted bit by one cycle. For the last bit of a frame, `match` coincides with `done`.
- `bit_valid` low in SCAN:
  - No bit is accepted; run, `last_bit` and the counters hold.
  - `match` ← 0.
  - Gaps do not break a run.
- Simultaneous requests are resolved purely by `rr_ptr`. No requester is granted twice while another has held `req` high.

## Test plan
- N_REQ=4, FRAME_LEN=8, RUN_LEN=3; `req[1]` only, `bit_valid` constant, bits 1,1,1,0,0,0,1,1 → `grant`=4'b0010; `match` high after bits 3 and 6; `done` with `done_id`=1, `hit_count`=2, `aborted`=0.
- Bits 1×8 → `match` high after bits 3–8; `hit_count`=6. Bits 1,0,1,0,1,0,1,0 → `hit_count`=0, `match` never high.
- `req` = 4'b1111 held → grants in order 0,1,2,3,0; `grant` gap of 2 cycles between frames; `rr_ptr` wrap verified.
- `bit_valid` gaps inside 0,0,_,0,1,... (gap cycle ignored) → hit after the third 0 despite the gap; `match` low during the gap cycle.
- `req[2]` dropped after 5 accepted bits → `done` next cycle with `done_id`=2, `aborted`=1, `hit_count` counting only the first 5 bits; next requester granted.
- `rst_n` pulsed low mid-SCAN → all outputs 0 immediately (asynchronously); no `done`; after release, arbitration restarts from requester 0.
